// File: rtl/instr_encoder_pkg.sv
// Shared types and field-packing helpers for the RV32I instruction encoder.
// The put_*_imm helpers return instr[31:7] with only the immediate bits placed.
package instr_encoder_pkg;

  typedef enum logic [4:0] {
    OPC_LOAD     = 5'b00000,
    OPC_MISC_MEM = 5'b00011,
    OPC_OPIMM    = 5'b00100,
    OPC_AUIPC    = 5'b00101,
    OPC_STORE    = 5'b01000,
    OPC_OP       = 5'b01100,
    OPC_LUI      = 5'b01101,
    OPC_BRANCH   = 5'b11000,
    OPC_JALR     = 5'b11001,
    OPC_JAL      = 5'b11011,
    OPC_SYSTEM   = 5'b11100
  } opcodes_t;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_BAD = 3'd6
  } instr_fmt_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  function automatic instr_fmt_t get_fmt(input opcodes_t op);
    case (op)
      OPC_OP:                         get_fmt = FMT_R;
      OPC_OPIMM, OPC_LOAD, OPC_JALR:  get_fmt = FMT_I;
      OPC_STORE:                      get_fmt = FMT_S;
      OPC_BRANCH:                     get_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:             get_fmt = FMT_U;
      OPC_JAL:                        get_fmt = FMT_J;
      default:                        get_fmt = FMT_BAD;
    endcase
  endfunction

  function automatic logic [24:0] put_I_imm(input logic [11:0] imm);
    put_I_imm = {imm, 13'd0};
  endfunction

  function automatic logic [24:0] put_S_imm(input logic [11:0] imm);
    put_S_imm = {imm[11:5], 13'd0, imm[4:0]};
  endfunction

  function automatic logic [24:0] put_B_imm(input logic [12:1] imm);
    put_B_imm = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11]};
  endfunction

  function automatic logic [24:0] put_U_imm(input logic [31:12] imm);
    put_U_imm = {imm, 5'd0};
  endfunction

  function automatic logic [24:0] put_J_imm(input logic [20:1] imm);
    put_J_imm = {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0};
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Small synchronous FIFO for encoded words; when empty the output shows the
// most recently popped entry so the consumer-facing data holds its last value.
module instr_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 42
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign dout  = empty ? mem[rd_ptr - PW'(1)] : mem[rd_ptr];

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: descriptor register, combinational pack, output FIFO.
// Optional immediate range checking is enabled with INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [31:0]       in_imm,
  input  logic              addr_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic              stage_valid;
  logic [4:0]        stage_op, stage_rd, stage_rs1, stage_rs2;
  logic [2:0]        stage_f3;
  logic              stage_alt;
  logic [31:0]       stage_imm;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] push_addr;
  logic [31:0]       enc;
  logic [31:0]       push_instr;
  logic              is_shift;
  instr_fmt_t        fmt;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              pop;
  logic              advance;

  assign pop      = out_valid && out_ready;
  assign advance  = stage_valid && ((fifo_count != FULL_CNT) || pop);
  assign in_ready = !rst && (!stage_valid || advance);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_op    <= 5'd0;
      stage_rd    <= 5'd0;
      stage_rs1   <= 5'd0;
      stage_rs2   <= 5'd0;
      stage_f3    <= 3'd0;
      stage_alt   <= 1'b0;
      stage_imm   <= 32'd0;
    end else if (in_valid && in_ready) begin
      stage_valid <= 1'b1;
      stage_op    <= in_op;
      stage_rd    <= in_rd;
      stage_rs1   <= in_rs1;
      stage_rs2   <= in_rs2;
      stage_f3    <= in_funct3;
      stage_alt   <= in_alt;
      stage_imm   <= in_imm;
    end else if (advance) begin
      stage_valid <= 1'b0;
    end else begin
      stage_valid <= stage_valid;
    end
  end

  // SLLI/SRLI/SRAI carry funct7 in the upper immediate bits
  assign fmt      = get_fmt(opcodes_t'(stage_op));
  assign is_shift = (stage_op == OPC_OPIMM) && (stage_f3[1:0] == 2'b01);

  always_comb begin
    enc = NOP_INSTR;
    case (fmt)
      FMT_R: enc = {1'b0, stage_alt, 5'd0, stage_rs2, stage_rs1, stage_f3, stage_rd, stage_op, 2'b11};
      FMT_I: begin
        if (is_shift) begin
          enc = {1'b0, stage_alt, 5'd0, stage_imm[4:0], stage_rs1, stage_f3, stage_rd, stage_op, 2'b11};
        end else begin
          enc = {put_I_imm(stage_imm[11:0]) | {12'd0, stage_rs1, stage_f3, stage_rd}, stage_op, 2'b11};
        end
      end
      FMT_S: enc = {put_S_imm(stage_imm[11:0]) | {7'd0, stage_rs2, stage_rs1, stage_f3, 5'd0}, stage_op, 2'b11};
      FMT_B: enc = {put_B_imm(stage_imm[12:1]) | {7'd0, stage_rs2, stage_rs1, stage_f3, 5'd0}, stage_op, 2'b11};
      FMT_U: enc = {put_U_imm(stage_imm[31:12]) | {20'd0, stage_rd}, stage_op, 2'b11};
      FMT_J: enc = {put_J_imm(stage_imm[20:1]) | {20'd0, stage_rd}, stage_op, 2'b11};
      default: enc = NOP_INSTR;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic viol;
  logic err_r;

  always_comb begin
    viol = 1'b0;
    case (fmt)
      FMT_R:   viol = 1'b0;
      FMT_I:   viol = is_shift ? (stage_imm[31:5] != 27'd0)
                               : !((&stage_imm[31:11]) || !(|stage_imm[31:11]));
      FMT_S:   viol = !((&stage_imm[31:11]) || !(|stage_imm[31:11]));
      FMT_B:   viol = !((&stage_imm[31:12]) || !(|stage_imm[31:12])) || stage_imm[0];
      FMT_U:   viol = (stage_imm[11:0] != 12'd0);
      FMT_J:   viol = !((&stage_imm[31:20]) || !(|stage_imm[31:20])) || stage_imm[0];
      default: viol = 1'b1;
    endcase
  end

  assign push_instr = viol ? NOP_INSTR : enc;

  // A fresh violation wins over a same-cycle clear so it is never lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (advance && viol) begin
      err_r <= 1'b1;
    end else if (addr_clr) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign push_instr = enc;
  assign err        = 1'b0;
`endif

  assign push_addr = addr_clr ? '0 : addr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt <= '0;
    end else if (addr_clr) begin
      addr_cnt <= advance ? ADDR_W'(1) : '0;
    end else if (advance) begin
      addr_cnt <= addr_cnt + ADDR_W'(1);
    end else begin
      addr_cnt <= addr_cnt;
    end
  end

  instr_enc_fifo #(
    .DEPTH (DEPTH),
    .W     (32 + ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (advance),
    .din   ({push_instr, push_addr}),
    .pop   (pop),
    .dout  ({out_instr, out_addr}),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a randomized
// run scored against an arithmetic reference encoder.
module tb_instr_encoder;
  localparam int AW = 3;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_op = 5'd0, in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [2:0]    in_funct3 = 3'd0;
  logic          in_alt = 1'b0;
  logic [31:0]   in_imm = 32'd0;
  logic          addr_clr = 1'b0;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err;

  logic          dir_ready = 1'b1;
  logic          rnd_ready = 1'b1;
  logic          rnd_on = 1'b0;
  logic          mon_en = 1'b0;
  int            n_chk = 0;
  int            n_fail = 0;
  logic [31:0]   eq_instr[$];
  logic [AW-1:0] eq_addr[$];
  logic [AW-1:0] model_addr = '0;
  logic          model_err = 1'b0;

  assign out_ready = rnd_on ? rnd_ready : dir_ready;

  instr_encoder #(.DEPTH(4), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm),
    .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Reference encoder built from the field-placement rules with shifts and masks
  function automatic logic [31:0] ref_enc(input logic [4:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic alt, input logic [31:0] imm, output logic bad);
    logic [31:0] w;
    logic [31:0] regs;
    int si;
    si   = $signed(imm);
    regs = (32'(rs1) << 15) | (32'(f3) << 12);
    bad  = 1'b0;
    case (op)
      5'h0C: w = (32'(alt) << 30) | (32'(rs2) << 20) | regs | (32'(rd) << 7);
      5'h04, 5'h00, 5'h19: begin
        if (op == 5'h04 && (f3 == 3'd1 || f3 == 3'd5)) begin
          w   = (32'(alt) << 30) | ((imm & 32'h1F) << 20) | regs | (32'(rd) << 7);
          bad = (imm > 32'd31);
        end else begin
          w   = ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7);
          bad = (si < -2048 || si > 2047);
        end
      end
      5'h08: begin
        w   = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs | ((imm & 32'h1F) << 7);
        bad = (si < -2048 || si > 2047);
      end
      5'h18: begin
        w   = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) |
              regs | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
        bad = (si < -4096 || si > 4095 || imm[0]);
      end
      5'h0D, 5'h05: begin
        w   = (imm & 32'hFFFFF000) | (32'(rd) << 7);
        bad = ((imm & 32'hFFF) != 32'd0);
      end
      5'h1B: begin
        w   = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
              (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7);
        bad = (si < -(1 << 20) || si > (1 << 20) - 1 || imm[0]);
      end
      default: begin
        w   = 32'd0;
        bad = 1'b1;
      end
    endcase
    if (w == 32'd0 && bad && !(op inside {5'h0C, 5'h04, 5'h00, 5'h19, 5'h08, 5'h18, 5'h0D, 5'h05, 5'h1B}))
      ref_enc = NOP;
    else
      ref_enc = w | (32'(op) << 2) | 32'd3;
`ifdef INSTR_ENC_RANGE_CHECK_EN
    if (bad) ref_enc = NOP;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    addr_clr = 1'b1;
    tick();
    addr_clr = 1'b0;
  endtask

  // Hold a descriptor until accepted; enters and returns just after a rising edge
  task automatic put_desc(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic alt, input logic [31:0] imm);
    int n;
    logic b;
    logic [31:0] w;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_alt = alt; in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    else if (mon_en) begin
      w = ref_enc(op, rd, rs1, rs2, f3, alt, imm, b);
      eq_instr.push_back(w);
      eq_addr.push_back(model_addr);
      model_addr++;
`ifdef INSTR_ENC_RANGE_CHECK_EN
      if (b) model_err = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for a head word, compare it, let it pop on the next edge
  task automatic get_word(input string tag, input logic [31:0] exp_instr, input logic [AW-1:0] exp_addr);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_instr"}, out_instr, exp_instr);
    chk({tag, "_addr"}, 32'(out_addr), 32'(exp_addr));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (eq_instr.size() == 0) begin
        chk("rnd_unexpected_word", 32'd1, 32'd0);
      end else begin
        chk("rnd_instr", out_instr, eq_instr.pop_front());
        chk("rnd_addr", 32'(out_addr), 32'(eq_addr.pop_front()));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic        b;
    logic [4:0]  ops [9] = '{5'h00, 5'h04, 5'h19, 5'h0C, 5'h08, 5'h18, 5'h0D, 5'h05, 5'h1B};
    logic [4:0]  r_op;
    logic [31:0] r_imm;
    int          n;

    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ADDI x1,x0,-1 with latency check
    put_desc(5'h04, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFFFFF);
    chk("addi_lat_early", 32'(out_valid), 32'd0);
    tick();
    chk("addi_lat_valid", 32'(out_valid), 32'd1);
    chk("addi_instr", out_instr, 32'hFFF00093);
    chk("addi_addr", 32'(out_addr), 32'd0);
    tick();

    pulse_clr();
    put_desc(5'h0C, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);
    put_desc(5'h0D, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000);
    get_word("sub", 32'h402081B3, 3'd0);
    get_word("lui", 32'h123452B7, 3'd1);
    put_desc(5'h18, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8);
    get_word("beq", 32'h00208463, 3'd2);
    put_desc(5'h1B, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048);
    get_word("jal", 32'h001000EF, 3'd3);

    // Backpressure: 4 words in FIFO, 1 in stage, sixth held off
    pulse_clr();
    dir_ready = 1'b0;
    for (int i = 1; i <= 5; i++) put_desc(5'h04, 5'(i), 5'd0, 5'd0, 3'd0, 1'b0, 32'(i));
    in_op = 5'h04; in_rd = 5'd6; in_imm = 32'd6; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    tick();
    tick();
    @(negedge clk);
    chk("bp_hold_instr", out_instr, ref_enc(5'h04, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1, b));
    chk("bp_hold_addr", 32'(out_addr), 32'd0);
    chk("bp_in_ready2", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    dir_ready = 1'b1;
    fork
      put_desc(5'h04, 5'd6, 5'd0, 5'd0, 3'd0, 1'b0, 32'd6);
      for (int i = 1; i <= 6; i++)
        get_word("bp_drain", ref_enc(5'h04, 5'(i), 5'd0, 5'd0, 3'd0, 1'b0, 32'(i), b), AW'(i - 1));
    join
    // Counter wraps at 2^AW
    for (int i = 7; i <= 9; i++) begin
      put_desc(5'h04, 5'(i), 5'd0, 5'd0, 3'd0, 1'b0, 32'(i));
      get_word("wrap", ref_enc(5'h04, 5'(i), 5'd0, 5'd0, 3'd0, 1'b0, 32'(i), b), AW'(i - 1));
    end

    // addr_clr on the same edge as a push
    put_desc(5'h04, 5'd10, 5'd0, 5'd0, 3'd0, 1'b0, 32'd10);
    pulse_clr();
    get_word("clr_push", ref_enc(5'h04, 5'd10, 5'd0, 5'd0, 3'd0, 1'b0, 32'd10, b), 3'd0);
    put_desc(5'h04, 5'd11, 5'd0, 5'd0, 3'd0, 1'b0, 32'd11);
    get_word("clr_next", ref_enc(5'h04, 5'd11, 5'd0, 5'd0, 3'd0, 1'b0, 32'd11, b), 3'd1);

    // ADDI x0,x0,2048: out of range
    put_desc(5'h04, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    get_word("range", 32'h00000013, 3'd2);
    chk("range_err", 32'(err), 32'd1);
    tick();
    chk("range_err_sticky", 32'(err), 32'd1);
`else
    get_word("range", 32'h80000013, 3'd2);
    chk("range_err", 32'(err), 32'd0);
`endif
    pulse_clr();
    chk("range_err_clr", 32'(err), 32'd0);

    // Reset mid-stream discards pending words
    dir_ready = 1'b0;
    for (int i = 1; i <= 3; i++) put_desc(5'h0C, 5'(i), 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_instr", out_instr, 32'd0);
    tick();
    rst = 1'b0;
    dir_ready = 1'b1;
    tick();
    chk("mid_rst_empty", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);

    // Randomized run against the reference model
    eq_instr.delete();
    eq_addr.delete();
    model_addr = '0;
    model_err  = 1'b0;
    mon_en = 1'b1;
    rnd_on = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        tick();
      end else begin
        r_op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 8)];
        case ($urandom_range(0, 4))
          0:       r_imm = 32'($urandom_range(0, 40));
          1:       r_imm = 32'($urandom_range(0, 4200)) - 32'd2100;
          2:       r_imm = $urandom;
          3:       r_imm = (32'($urandom_range(0, 2000)) - 32'd1000) << 1;
          default: r_imm = $urandom & 32'hFFFFF000;
        endcase
        put_desc(r_op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 1'($urandom), r_imm);
      end
    end
    rnd_on = 1'b0;
    n = 0;
    while (eq_instr.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    @(negedge clk);
    chk("rnd_drain", 32'(eq_instr.size()), 32'd0);
    chk("rnd_out_valid_idle", 32'(out_valid), 32'd0);
    chk("rnd_err", 32'(err), 32'(model_err));
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RISC-V RV32I instruction encoder. It is the write-side counterpart of the core's decode helpers. It accepts decoded instruction fields (opcode, registers, funct3, ALU alternate bit and a full architectural immediate) over a valid/ready handshake. It packs them into 32-bit instruction words and emits each word with a sequential instruction-memory word address through a small output FIFO. It is used by the boot loader and the self-test program generator to fill instruction memory.

## Interface
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- ADDR_W, 10, instruction-memory word-address width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input descriptor valid
- in_ready  out  1  encoder can accept descriptor
- in_op  in  5  opcodes_t (instruction bits [6:2])
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3
- in_alt  in  1  funct7[5] (SUB/SRA/SRAI)
- in_imm  in  32  architectural immediate, unshifted byte offset / value
- addr_clr  in  1  synchronous address counter clear
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_instr  out  32  encoded word
- out_addr  out  ADDR_W  word address of out_instr
- err  out  1  sticky range-check error (see Configuration)

## Operation
- Stage 1: descriptor register, loaded on in_valid && in_ready.
- Stage 2: combinational encode of the stage-1 fields, pushed into the FIFO together with the address counter value.
- Stage 1 advances when FIFO count < DEPTH, or when a pop happens in the same cycle. in_ready = !stage_valid || advance.
- Instruction bits [1:0] = 2'b11; bits [6:2] = in_op. Fields unused by a format are zero.
- R (OP): {0,alt,00000, rs2, rs1, f3, rd, op}.
- I (OPIMM, LOAD, JALR): imm[11:0], rs1, f3, rd. For OPIMM with f3 = 001 or 101: imm[11:5] = {0,alt,00000} and imm[4:0] = in_imm[4:0].
- S: imm[11:5], rs2, rs1, f3, imm[4:0].
- B: imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11].
- U (LUI, AUIPC): imm[31:12], rd.
- J: imm[20], imm[10:1], imm[11], imm[19:12], rd.
- Unsupported opcode: encodes NOP 0x00000013.
- Address counter: increments on every FIFO push and wraps from 2^ADDR_W−1 to 0.
- addr_clr has priority. A push in the same cycle gets address 0 and the counter becomes 1.
- FIFO full with simultaneous pop: push is accepted. FIFO empty: out_valid low and out_instr/out_addr hold the last value.

## Timing
- Latency: descriptor accepted at edge N, out_valid high after edge N+1 (FIFO empty, out_ready high).
- Throughput: one word per cycle with no backpressure.
- Reset values: in_ready 0 while rst is high, 1 after release. out_valid 0, out_instr 0, out_addr 0, err 0. Counter 0, stage and FIFO empty.
- Reset mid-operation discards all pending words.
- out_instr and out_addr are stable while out_valid && !out_ready.

## Configuration
- INSTR_ENC_RANGE_CHECK_EN defined: stage 2 checks the immediate before encoding.
  - Rules: I/S fit 12-bit signed; B fits 13-bit signed with bit0 = 0; J fits 21-bit signed with bit0 = 0; U has low 12 bits zero; shift amount < 32; unsupported opcode.
  - On violation: push NOP 0x00000013 and set err. err stays set until rst or addr_clr.
- Undefined: immediates are silently truncated to the format and err is tied 0.

## Structure
- Shared coreUtils package additions:
  - instr_fmt_t enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD}
  - get_fmt(opcodes_t)
  - put_I_imm / put_S_imm / put_B_imm / put_U_imm / put_J_imm, returning the 25-bit field the existing get_*_imm functions invert
  - NOP_INSTR constant 32'h00000013
- One sub-module: instr_enc_fifo (DEPTH × (32+ADDR_W), push/pop/count).

## Test plan
- ADDI x1,x0,−1 (OPIMM, f3=0, imm=0xFFFFFFFF) -> 0xFFF00093 at addr 0, out_valid high one cycle after the accept edge.
- SUB x3,x1,x2 (OP, f3=0, alt=1) then LUI x5, imm 0x12345000 -> 0x402081B3 at addr 0, then 0x123452B7 at addr 1.
- BEQ x1,x2,+8 -> 0x00208463. JAL x1,+2048 -> 0x001000EF.
- Backpressure with out_ready=0: push 6 descriptors. Expect 4 in the FIFO, 1 in stage, in_ready low. Release out_ready: words drain in order with addrs 0..4, then word 6 follows.
- ADDR_W=2: push 5 words -> addrs 0,1,2,3,0. addr_clr coincident with a push -> that word gets addr 0, next gets addr 1. rst mid-stream -> out_valid 0 next cycle, FIFO empty.
- ADDI imm=2048: with macro -> 0x00000013 and err=1 until addr_clr. Without macro -> 0x80000013 and err=0.
